jk_stream_driver: RTL and testbench

- Serializes parallel data words into J/K excitation for one external negedge-clocked JK flip-flop. Encoding: jk[1]=J, jk[0]=K; 00 hold, 01 reset, 10 set, 11 toggle.
- Watches the flip-flop's q output and flags any bit that did not land as commanded.
- Sits between a valid/ready word source and the JK storage element, as that element's driver.

---
 rtl/jk_drv_pkg.sv | 16 +
 rtl/jk_stream_driver_if.sv | 13 +
 rtl/jk_excite.sv | 22 ++
 rtl/jk_stream_driver.sv | 120 ++++++++++++
 tb/tb_jk_stream_driver.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/jk_drv_pkg.sv
// rtl/jk_drv_pkg.sv - shared J/K excitation codes, FSM state type and counter width
package jk_drv_pkg;

  localparam logic [1:0] JK_HOLD   = 2'b00;
  localparam logic [1:0] JK_RESET  = 2'b01;
  localparam logic [1:0] JK_SET    = 2'b10;
  localparam logic [1:0] JK_TOGGLE = 2'b11;

  localparam int MIS_CNT_W = 8;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

endpackage

// File: rtl/jk_stream_driver_if.sv
// rtl/jk_stream_driver_if.sv - valid/ready word handshake into the JK stream driver
interface jk_stream_driver_if #(
  parameter int WIDTH = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);

endinterface

// File: rtl/jk_excite.sv
// rtl/jk_excite.sv - picks the {J,K} code that moves a flip-flop from q to d
module jk_excite
  import jk_drv_pkg::*;
(
  input  logic       q,
  input  logic       d,
  input  logic       first,
  input  logic       use_toggle,
  output logic [1:0] jk
);

  // The first bit of a word is always forced explicitly since q may be unknown.
  always_comb begin
    jk = JK_HOLD;
    if (first) begin
      jk = d ? JK_SET : JK_RESET;
    end else if (q != d) begin
      jk = use_toggle ? JK_TOGGLE : (d ? JK_SET : JK_RESET);
    end
  end

endmodule

// File: rtl/jk_stream_driver.sv
// rtl/jk_stream_driver.sv - serializes words into J/K excitation and checks the landed q
module jk_stream_driver
  import jk_drv_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int MSB_FIRST   = 1,
  parameter int USE_TOGGLE  = 0,
  parameter int STOP_ON_ERR = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  jk_stream_driver_if.slave    src,
  input  logic                 q_fb,
  output logic [1:0]           jk,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  input  logic                 err_clr,
  output logic [MIS_CNT_W-1:0] mis_cnt
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t           state, state_n;
  logic [WIDTH-1:0] sreg;
  logic [CNT_W-1:0] cnt;
  logic             exp_bit;
  logic             next_bit;
  logic             mismatch, last, abort, load, advance;
  logic             done_n;
  logic [1:0]       exc_jk, jk_n;

  // Keeps the next bit to send at a fixed end of the register.
  function automatic logic [WIDTH-1:0] shift_out(input logic [WIDTH-1:0] x);
    if (MSB_FIRST != 0) return {x[WIDTH-2:0], 1'b0};
    else                return {1'b0, x[WIDTH-1:1]};
  endfunction

  assign src.in_ready = (state == IDLE);
  assign busy         = (state == SHIFT);

  always_comb begin
    next_bit = 1'b0;
    if (state == IDLE) next_bit = (MSB_FIRST != 0) ? src.in_data[WIDTH-1] : src.in_data[0];
    else               next_bit = (MSB_FIRST != 0) ? sreg[WIDTH-1] : sreg[0];
  end

  jk_excite u_excite (
    .q          (q_fb),
    .d          (next_bit),
    .first      (state == IDLE),
    .use_toggle (USE_TOGGLE != 0),
    .jk         (exc_jk)
  );

  always_comb begin
    state_n  = state;
    jk_n     = JK_HOLD;
    done_n   = 1'b0;
    load     = 1'b0;
    advance  = 1'b0;
    mismatch = (state == SHIFT) && (q_fb != exp_bit);
    last     = (cnt == CNT_W'(WIDTH));
    abort    = mismatch && (STOP_ON_ERR != 0);
    case (state)
      IDLE: begin
        if (src.in_valid) begin
          state_n = SHIFT;
          jk_n    = exc_jk;
          load    = 1'b1;
        end
      end
      SHIFT: begin
        if (last || abort) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end else begin
          jk_n    = exc_jk;
          advance = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      jk      <= JK_HOLD;
      done    <= 1'b0;
      err     <= 1'b0;
      mis_cnt <= '0;
      cnt     <= '0;
      sreg    <= '0;
      exp_bit <= 1'b0;
    end else begin
      state <= state_n;
      jk    <= jk_n;
      done  <= done_n;
      if (load) begin
        sreg    <= shift_out(src.in_data);
        cnt     <= CNT_W'(1);
        exp_bit <= next_bit;
      end else if (advance) begin
        sreg    <= shift_out(sreg);
        cnt     <= cnt + CNT_W'(1);
        exp_bit <= next_bit;
      end
      // A mismatch on the clearing edge is kept so it is never lost.
      if (err_clr) begin
        err     <= mismatch;
        mis_cnt <= mismatch ? MIS_CNT_W'(1) : '0;
      end else if (mismatch) begin
        err <= 1'b1;
        if (mis_cnt != '1) mis_cnt <= mis_cnt + MIS_CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_jk_stream_driver.sv
// tb/tb_jk_stream_driver.sv - scoreboard bench driving four parameter variants into JK flip-flop models
module tb_jk_stream_driver;
  import jk_drv_pkg::*;

  localparam int W = 8;
  localparam int N = 4;

  typedef struct {
    logic [1:0] jk;
    logic       done;
    logic       busy;
    logic       err;
    logic [7:0] cnt;
    logic       qv;
    logic       q;
  } rec_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     valid_i, qf_en, clr_i;
  logic [W-1:0]     data_i [N];
  logic [N-1:0][1:0] jk_o;
  logic [N-1:0][7:0] cnt_o;
  logic [N-1:0]     busy_o, done_o, err_o, rdy_o, qfb, qff;

  int   vectors = 0;
  int   miscompares = 0;
  int   m_cnt [N];
  bit   m_err [N];
  rec_t sb [$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    logic q = 1'b0;
    jk_stream_driver_if #(.WIDTH(W)) bus ();
    assign bus.in_valid = valid_i[g];
    assign bus.in_data  = data_i[g];
    assign rdy_o[g]     = bus.in_ready;
    assign qff[g]       = q;
    assign qfb[g]       = qf_en[g] ? 1'b0 : q;

    jk_stream_driver #(
      .WIDTH       (W),
      .MSB_FIRST   ((g == 3) ? 0 : 1),
      .USE_TOGGLE  ((g == 1) ? 1 : 0),
      .STOP_ON_ERR ((g == 2) ? 1 : 0)
    ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .src     (bus),
      .q_fb    (qfb[g]),
      .jk      (jk_o[g]),
      .busy    (busy_o[g]),
      .done    (done_o[g]),
      .err     (err_o[g]),
      .err_clr (clr_i[g]),
      .mis_cnt (cnt_o[g])
    );

    always @(negedge clk) begin
      case (jk_o[g])
        2'b01:   q <= 1'b0;
        2'b10:   q <= 1'b1;
        2'b11:   q <= ~q;
        default: q <= q;
      endcase
    end
  end

  task automatic chk(input string tag, input int g, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, g, obs, exp);
    end
  endtask

  function automatic logic [1:0] exc(input bit q, input bit d, input bit ut);
    if (q == d) return 2'b00;
    if (ut)     return 2'b11;
    return d ? 2'b10 : 2'b01;
  endfunction

  function automatic bit ff_next(input logic [1:0] j, input bit q);
    case (j)
      2'b01:   return 1'b0;
      2'b10:   return 1'b1;
      2'b11:   return ~q;
      default: return q;
    endcase
  endfunction

  // f: compare edge whose q_fb is forced low; fall: force for the whole word; clr_at: err_clr edge.
  task automatic run_word(input int g, input logic [W-1:0] w, input bit nv, input logic [W-1:0] nd,
                          input int f, input bit fall, input int clr_at);
    bit b [W];
    bit ut, soe, qm, qfbm, mis;
    logic [1:0] j;
    rec_t r;
    int c;
    ut  = (g == 1);
    soe = (g == 2);
    for (int i = 0; i < W; i++) b[i] = (g == 3) ? w[i] : w[W-1-i];
    j = b[0] ? 2'b10 : 2'b01;
    r = '{jk: j, done: 1'b0, busy: 1'b1, err: m_err[g], cnt: 8'(m_cnt[g]), qv: 1'b0, q: 1'b0};
    sb.push_back(r);
    qm = b[0];
    for (int i = 1; i <= W; i++) begin
      qfbm = (fall || i == f) ? 1'b0 : qm;
      mis  = (qfbm != b[i-1]);
      if (i == clr_at) begin
        m_err[g] = mis;
        m_cnt[g] = mis ? 1 : 0;
      end else if (mis) begin
        m_err[g] = 1'b1;
        if (m_cnt[g] < 255) m_cnt[g]++;
      end
      r.qv = 1'b1; r.q = qm; r.err = m_err[g]; r.cnt = 8'(m_cnt[g]);
      if (i == W || (mis && soe)) begin
        r.jk = 2'b00; r.done = 1'b1; r.busy = 1'b0;
        sb.push_back(r);
        break;
      end
      j = exc(qfbm, b[i], ut);
      r.jk = j; r.done = 1'b0; r.busy = 1'b1;
      sb.push_back(r);
      qm = ff_next(j, qm);
    end

    valid_i[g] = 1'b1;
    data_i[g]  = w;
    qf_en[g]   = fall;
    c = 0;
    while (sb.size() > 0) begin
      @(posedge clk); #1;
      if (c == 0) begin
        valid_i[g] = nv;
        data_i[g]  = nd;
      end
      r = sb.pop_front();
      chk("jk", g, 8'(jk_o[g]), 8'(r.jk));
      chk("done", g, 8'(done_o[g]), 8'(r.done));
      chk("busy", g, 8'(busy_o[g]), 8'(r.busy));
      chk("in_ready", g, 8'(rdy_o[g]), 8'(!r.busy));
      chk("err", g, 8'(err_o[g]), 8'(r.err));
      chk("mis_cnt", g, cnt_o[g], r.cnt);
      if (r.qv) chk("q", g, 8'(qff[g]), 8'(r.q));
      qf_en[g] = fall || (c + 1 == f);
      clr_i[g] = (c + 1 == clr_at);
      c++;
    end
    qf_en[g] = 1'b0;
    clr_i[g] = 1'b0;
  endtask

  initial begin
    rst_n   = 1'b0;
    valid_i = '0;
    qf_en   = '0;
    clr_i   = '0;
    for (int g = 0; g < N; g++) begin
      data_i[g] = '0;
      m_cnt[g]  = 0;
      m_err[g]  = 1'b0;
    end
    #12;
    for (int g = 0; g < N; g++) begin
      chk("rst_jk", g, 8'(jk_o[g]), 8'(JK_HOLD));
      chk("rst_ready", g, 8'(rdy_o[g]), 8'd1);
      chk("rst_busy", g, 8'(busy_o[g]), 8'd0);
      chk("rst_done", g, 8'(done_o[g]), 8'd0);
      chk("rst_err", g, 8'(err_o[g]), 8'd0);
      chk("rst_cnt", g, cnt_o[g], 8'd0);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    run_word(0, 8'b1011_0010, 1'b0, 8'h00, -1, 1'b0, -1);
    run_word(1, 8'hA5, 1'b0, 8'h00, -1, 1'b0, -1);
    run_word(0, 8'hFF, 1'b0, 8'h00, 3, 1'b0, -1);
    run_word(2, 8'hFF, 1'b0, 8'h00, 3, 1'b0, -1);
    run_word(3, 8'h01, 1'b0, 8'h00, -1, 1'b0, -1);

    for (int k = 0; k < 38; k++) run_word(0, 8'hFF, 1'b0, 8'h00, -1, 1'b1, -1);
    chk("sat_cnt", 0, cnt_o[0], 8'd255);
    run_word(0, 8'hFF, 1'b0, 8'h00, 3, 1'b0, 3);
    chk("clr_coinc_cnt", 0, cnt_o[0], 8'd1);
    chk("clr_coinc_err", 0, 8'(err_o[0]), 8'd1);
    run_word(0, 8'h3C, 1'b0, 8'h00, -1, 1'b0, 2);

    valid_i[0] = 1'b1;
    data_i[0]  = 8'hFF;
    qf_en[0]   = 1'b1;
    @(posedge clk); #1;
    valid_i[0] = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_err", 0, 8'(err_o[0]), 8'd1);
    chk("pre_rst_busy", 0, 8'(busy_o[0]), 8'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_jk", 0, 8'(jk_o[0]), 8'(JK_HOLD));
    chk("async_busy", 0, 8'(busy_o[0]), 8'd0);
    chk("async_err", 0, 8'(err_o[0]), 8'd0);
    chk("async_cnt", 0, cnt_o[0], 8'd0);
    chk("async_ready", 0, 8'(rdy_o[0]), 8'd1);
    qf_en[0] = 1'b0;
    for (int g = 0; g < N; g++) begin
      m_cnt[g] = 0;
      m_err[g] = 1'b0;
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    run_word(0, 8'h80, 1'b1, 8'h00, -1, 1'b0, -1);
    run_word(0, 8'h00, 1'b0, 8'h00, -1, 1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
